// File: rtl/sb_cfg_pkg.sv
// Shared types and sizing helpers for the switch-block configuration loader.
package sb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } sb_cfg_state_e;

    localparam int unsigned DEF_NUM_SB          = 32'd4;
    localparam int unsigned DEF_CFG_BITS_PER_SB = 32'd24;
    localparam int unsigned DEF_WORD_WIDTH      = 32'd8;
    localparam int unsigned TOTAL_BITS          = DEF_NUM_SB * DEF_CFG_BITS_PER_SB;
    localparam int unsigned TOTAL_WORDS         = TOTAL_BITS / DEF_WORD_WIDTH;

    // Width able to hold every value 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

    function automatic int unsigned total_words(input int unsigned num_sb,
                                                input int unsigned bits_per_sb,
                                                input int unsigned word_width);
        return (num_sb * bits_per_sb) / word_width;
    endfunction

    // Parity bit that makes the word plus parity carry an even number of ones.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sb_cfg_serializer.sv
// Word-wide load/shift register feeding the scan chain LSB-first, with its
// remaining-bit counter. Empty means no bits are left to shift.
module sb_cfg_serializer
    import sb_cfg_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] data,
    output logic                  empty,
    output logic                  last_bit,
    output logic                  cfg_sdo,
    output logic                  cfg_shift_en
);

    localparam int BC_W = int'(cnt_width(WORD_WIDTH));

    logic [WORD_WIDTH-1:0] shreg_r;
    logic [BC_W-1:0]       bit_cnt_r;
    logic                  shift_en_s;

    // Shift register and remaining-bit count; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r   <= {WORD_WIDTH{1'b0}};
            bit_cnt_r <= {BC_W{1'b0}};
        end else if (clear) begin
            shreg_r   <= {WORD_WIDTH{1'b0}};
            bit_cnt_r <= {BC_W{1'b0}};
        end else if (load) begin
            shreg_r   <= data;
            bit_cnt_r <= BC_W'(WORD_WIDTH);
        end else if (shift_en_s) begin
            shreg_r   <= {1'b0, shreg_r[WORD_WIDTH-1:1]};
            bit_cnt_r <= bit_cnt_r - BC_W'(1);
        end
    end

    assign shift_en_s   = (bit_cnt_r != {BC_W{1'b0}});
    assign empty        = ~shift_en_s;
    assign last_bit     = (bit_cnt_r == BC_W'(1));
    assign cfg_shift_en = shift_en_s;
    assign cfg_sdo      = shift_en_s & shreg_r[0];

endmodule

// File: rtl/sb_config_loader.sv
// Streams configuration words onto the switch-block scan chain and strobes a
// common latch once the whole chain is filled. Optional: CFG_PARITY_EN.
module sb_config_loader
    import sb_cfg_pkg::*;
#(
    parameter int CHANNEL_ONEWAY_WIDTH = 4,
    parameter int NUM_SB               = 4,
    parameter int CFG_BITS_PER_SB      = 24,
    parameter int WORD_WIDTH           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_parity,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  cfg_sdo,
    output logic                  cfg_shift_en,
    output logic                  cfg_latch,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int LOAD_WORDS = int'(total_words(NUM_SB, CFG_BITS_PER_SB, WORD_WIDTH));
    localparam int WC_W       = int'(cnt_width(LOAD_WORDS));

    sb_cfg_state_e   state_r;
    sb_cfg_state_e   state_next_s;
    logic [WC_W-1:0] word_cnt_r;
    logic            error_r;
    logic            ser_empty_s;
    logic            ser_last_bit_s;
    logic            ser_clear_s;
    logic            ser_load_s;
    logic            in_ready_s;
    logic            handshake_s;
    logic            parity_err_s;
    logic            start_accept_s;
    logic            last_word_s;
    logic [32:0]     unused_cfg_s;

    assign start_accept_s = start & ((state_r == IDLE) | (state_r == DONE));
    assign handshake_s    = (state_r == SHIFT) & in_ready_s & in_valid & ~abort;
    assign last_word_s    = (word_cnt_r == WC_W'(LOAD_WORDS));

`ifdef CFG_PARITY_EN
    assign parity_err_s = handshake_s & (in_parity != even_parity(64'(in_data)));
    assign unused_cfg_s = {1'b0, 32'(CHANNEL_ONEWAY_WIDTH)};
`else
    assign parity_err_s = 1'b0;
    assign unused_cfg_s = {in_parity, 32'(CHANNEL_ONEWAY_WIDTH)};
`endif

    // A faulty word is dropped rather than shifted onto the chain.
    assign ser_load_s  = handshake_s & ~parity_err_s;
    assign ser_clear_s = abort | (state_r != SHIFT);

    sb_cfg_serializer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .clk          (clk),
        .rst          (rst),
        .clear        (ser_clear_s),
        .load         (ser_load_s),
        .data         (in_data),
        .empty        (ser_empty_s),
        .last_bit     (ser_last_bit_s),
        .cfg_sdo      (cfg_sdo),
        .cfg_shift_en (cfg_shift_en)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort outranks a same-cycle handshake and the last bit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = SHIFT;
                else       state_next_s = IDLE;
            end
            SHIFT: begin
                if (abort)                              state_next_s = IDLE;
                else if (parity_err_s)                  state_next_s = IDLE;
                else if (ser_last_bit_s && last_word_s) state_next_s = LATCH;
                else                                    state_next_s = SHIFT;
            end
            LATCH:   state_next_s = DONE;
            DONE: begin
                if (start) state_next_s = SHIFT;
                else       state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        in_ready_s = 1'b0;
        cfg_latch  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_r)
            IDLE:  ;
            SHIFT: begin
                in_ready_s = ser_empty_s;
                busy       = 1'b1;
            end
            LATCH: begin
                cfg_latch = 1'b1;
                busy      = 1'b1;
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign in_ready = in_ready_s;

    // Accepted-word counter, cleared outside SHIFT and on abort, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_r <= {WC_W{1'b0}};
        end else if (ser_clear_s) begin
            word_cnt_r <= {WC_W{1'b0}};
        end else if (ser_load_s && !last_word_s) begin
            word_cnt_r <= word_cnt_r + WC_W'(1);
        end
    end

    // Sticky parity error, cleared only by a new load or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_r <= 1'b0;
        end else if (start_accept_s) begin
            error_r <= 1'b0;
        end else if (parity_err_s) begin
            error_r <= 1'b1;
        end
    end

    assign error = error_r;

endmodule

// File: doc/sb_config_loader.md
# sb_config_loader

Configuration loader for the switch-block fabric. Accepts configuration words over a valid/ready stream, serializes them LSB-first onto a daisy-chained scan path through NUM_SB switch blocks, then pulses a latch so all blocks update their routing at once. Sits between the chip-level bitstream interface and the switch-block configuration chain.

## Interface
Parameters:
- CHANNEL_ONEWAY_WIDTH, 4: tracks per direction per switch block.
- NUM_SB, 4: switch blocks on the chain.
- CFG_BITS_PER_SB, 24: configuration bits per switch block.
- WORD_WIDTH, 8: input word width. NUM_SB*CFG_BITS_PER_SB must be a multiple of WORD_WIDTH.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE or DONE.
- abort  input  1  cancel a load in progress; no latch is issued.
- in_data  input  WORD_WIDTH  configuration word.
- in_parity  input  1  even parity of in_data (used only with CFG_PARITY_EN).
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a word this cycle.
- cfg_sdo  output  1  scan data to the first switch block.
- cfg_shift_en  output  1  chain shifts one bit this cycle.
- cfg_latch  output  1  one-cycle update strobe to all switch blocks.
- busy  output  1  high in SHIFT and LATCH.
- done  output  1  high in DONE.
- error  output  1  parity failure flag (tied 0 without CFG_PARITY_EN).

## Operation
- TOTAL_BITS = NUM_SB*CFG_BITS_PER_SB. TOTAL_WORDS = TOTAL_BITS/WORD_WIDTH (12 at defaults).
- States are IDLE, SHIFT, LATCH, DONE.
- IDLE, start=1: go to SHIFT. Clear word counter, bit counter, and error.
- SHIFT with the shift register empty: in_ready=1. A handshake (in_valid & in_ready) loads in_data into the shift register and increments the word counter.
- SHIFT with the shift register loaded: in_ready=0 and cfg_shift_en=1 for exactly WORD_WIDTH cycles. cfg_sdo is shreg[0] and the register shifts right each cycle.
- After the last bit of word TOTAL_WORDS is shifted: go to LATCH. cfg_latch=1 for one cycle, then go to DONE.
- DONE: done=1 and it holds there. start=1 goes to SHIFT, same as from IDLE.
- start while in SHIFT or LATCH: ignored.
- abort=1 in SHIFT: go to IDLE next cycle. The partial shift stops, there is no cfg_latch, and the counters clear. abort has priority over a same-cycle handshake, and the word is not accepted.
- abort in LATCH: ignored, the latch completes. abort in IDLE or DONE: no effect.
- Word counter width is $clog2(TOTAL_WORDS+1). Bit counter width is $clog2(WORD_WIDTH+1). Neither wraps; both saturate at their terminal value until the state changes.
- cfg_sdo is 0 whenever cfg_shift_en=0.

## Timing
- Reset values: state IDLE. in_ready, cfg_sdo, cfg_shift_en, cfg_latch, busy, done, and error are all 0.
- A reset asserted mid-load takes effect on the next edge. The chain is left partially shifted and no latch is issued.
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid to in_ready.
- Per word: 1 accept cycle plus WORD_WIDTH shift cycles, so there is no overlap between accept and shift.
- Total load time from start to cfg_latch is 1 + TOTAL_WORDS*(WORD_WIDTH+1) cycles, given in_valid is always high. That is 109 cycles at defaults.
- in_valid low stretches the accept cycle indefinitely. The loader never times out.

## Configuration
- CFG_PARITY_EN defined: each accepted word is checked against in_parity.
  - On a mismatch, error is set (sticky until the next start or rst), the FSM goes to IDLE, and no latch is issued.
  - The faulty word's bits are not shifted.
- CFG_PARITY_EN undefined: in_parity is ignored and error is constant 0.

## Structure
- Shared package sb_cfg_pkg holds:
  - the state enum: IDLE, SHIFT, LATCH, DONE;
  - the localparams TOTAL_BITS and TOTAL_WORDS;
  - the counter-width functions.
- One natural sub-module, sb_cfg_serializer: the WORD_WIDTH-bit load/shift register with its bit counter. It exposes an empty flag and drives cfg_sdo and cfg_shift_en.

## Test plan
- Nominal load at defaults: 12 words, 0x01 through 0x0C, with in_valid held high.
  - Required: cfg_latch pulses exactly once, 109 cycles after start.
  - A bench scan model of 96 bits holds word 0x01 at its far end.
  - done rises the cycle after cfg_latch.
- Backpressure: drop in_valid for 5 cycles before word 6.
  - Required: in_ready holds at 1 throughout, cfg_shift_en stays 0, and latch time extends by 5 cycles.
- Abort in SHIFT during bit 3 of word 4.
  - Required: next cycle is IDLE, cfg_shift_en=0, cfg_latch never asserts, and done=0.
- Start while busy at cycle 50 is ignored: load completes at cycle 109 with no restart.
- Reset at cycle 30: all outputs are 0 on the next cycle. A subsequent start performs a full 12-word load.
- CFG_PARITY_EN: word 3 is 0x07 with in_parity=0.
  - Required: error=1, state IDLE, no cfg_latch, and only 16 cfg_shift_en cycles in total.
  - A following start clears error.
